wb_rr_arb: RTL and testbench

WB_RR_ARB -- requirements
Module: wb_rr_arb

---
 rtl/wb_rr_arb.sv | 92 +++++++++
 tb/tb_wb_rr_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arb.sv
// Four-master round-robin bus arbiter with a hold-time watchdog.
// A master that exceeds its hold limit is masked until it drops its request.
module wb_rr_arb #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout_err
);

    localparam bit          WdogEn      = (TIMEOUT != 0);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [1:0]  r_owner;
    logic [15:0] r_cnt;
    logic [3:0]  r_mask;
    logic [3:0]  r_gnt;
    logic        r_terr;

    logic [3:0]  w_ereq;
    logic        w_hold;
    logic        w_fire;
    logic [1:0]  w_next;
    logic        w_found;
    logic [1:0]  w_owner_d;
    logic [15:0] w_cnt_d;
    logic [3:0]  w_mask_d;
    logic        w_terr_d;

    assign w_ereq = req & ~r_mask;
    assign w_hold = w_ereq[r_owner];
    assign w_fire = WdogEn && w_hold && (r_cnt == TimeoutLast);

    // Search starts after the owner, so a revoked owner is never reselected here.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = '0;
        w_next  = r_owner;
        w_found = 1'b0;
        for (int k = 1; k < 4; k++) begin
            v_idx = r_owner + 2'(k);
            if (!w_found && w_ereq[v_idx]) begin
                w_next  = v_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_d = r_owner;
        w_cnt_d   = '0;
        w_mask_d  = r_mask & req;
        w_terr_d  = 1'b0;
        if (w_fire) begin
            w_mask_d[r_owner] = 1'b1;
            w_terr_d          = 1'b1;
            if (w_found) begin
                w_owner_d = w_next;
            end
        end else if (w_hold) begin
            w_cnt_d = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end else if (w_found) begin
            w_owner_d = w_next;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_owner <= 2'd0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_gnt   <= 4'b0001;
            r_terr  <= 1'b0;
        end else begin
            r_owner <= w_owner_d;
            r_cnt   <= w_cnt_d;
            r_mask  <= w_mask_d;
            r_gnt   <= 4'b0001 << w_owner_d;
            r_terr  <= w_terr_d;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_owner;
    assign busy        = w_hold;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_wb_rr_arb.sv
// Directed bench for wb_rr_arb: three instances (TIMEOUT 8, 4, 0) sharing clock and reset;
// expected outputs are queued with each stimulus step and popped after the clock edge.
module tb_wb_rr_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [3:0] req_c = '0;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       busy_a, busy_b, busy_c;
    logic       terr_a, terr_b, terr_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] gnt;
        logic       busy;
        logic       terr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_rr_arb #(.TIMEOUT(8)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
        .busy(busy_a), .timeout_err(terr_a)
    );

    wb_rr_arb #(.TIMEOUT(4)) u_dut4 (
        .sys_clk(clk), .sys_rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
        .busy(busy_b), .timeout_err(terr_b)
    );

    wb_rr_arb #(.TIMEOUT(0)) u_dut0 (
        .sys_clk(clk), .sys_rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
        .busy(busy_c), .timeout_err(terr_c)
    );

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        unique case (g)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input logic [3:0] g, input logic b, input logic t,
                        input string tag);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.gnt  = g;
        e.busy = b;
        e.terr = t;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t       e;
        logic [3:0] og;
        logic [1:0] oi;
        logic       ob;
        logic       ot;
        e = sb.pop_front();
        case (e.sel)
            1:       begin og = gnt_b; oi = idx_b; ob = busy_b; ot = terr_b; end
            2:       begin og = gnt_c; oi = idx_c; ob = busy_c; ot = terr_c; end
            default: begin og = gnt_a; oi = idx_a; ob = busy_a; ot = terr_a; end
        endcase
        chk({e.tag, ".gnt"}, 32'(og), 32'(e.gnt));
        chk({e.tag, ".idx"}, 32'(oi), 32'(enc(e.gnt)));
        chk({e.tag, ".busy"}, 32'(ob), 32'(e.busy));
        chk({e.tag, ".terr"}, 32'(ot), 32'(e.terr));
    endtask

    // Drive req on one instance, then check that instance just after the next edge.
    task automatic cyc(input int sel, input logic [3:0] r, input logic [3:0] g,
                       input logic b, input logic t, input string tag);
        case (sel)
            1:       req_b = r;
            2:       req_c = r;
            default: req_a = r;
        endcase
        push(sel, g, b, t, tag);
        @(posedge clk);
        #1;
        pop_chk();
    endtask

    task automatic do_reset(input int sel, input string tag);
        rst = 1'b1;
        #1;
        push(sel, 4'b0001, 1'b0, 1'b0, tag);
        pop_chk();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        #2;
        do_reset(0, "reset");

        // Park on master 0, then a lone request from master 2.
        cyc(0, 4'b0000, 4'b0001, 1'b0, 1'b0, "park0");
        cyc(0, 4'b0000, 4'b0001, 1'b0, 1'b0, "park1");
        cyc(0, 4'b0100, 4'b0100, 1'b1, 1'b0, "req2");
        cyc(0, 4'b0100, 4'b0100, 1'b1, 1'b0, "hold2a");
        cyc(0, 4'b0100, 4'b0100, 1'b1, 1'b0, "hold2b");
        cyc(0, 4'b0000, 4'b0100, 1'b0, 1'b0, "park2");

        do_reset(0, "reset_rot");
        for (int m = 0; m < 4; m++) begin
            for (int h = 0; h < 3; h++) begin
                cyc(0, 4'b1111, 4'b0001 << m, 1'b1, 1'b0, $sformatf("rot_hold%0d", m));
            end
            cyc(0, 4'b1111 & ~(4'b0001 << m), 4'b0001 << ((m + 1) % 4), 1'b1, 1'b0,
                $sformatf("rot_switch%0d", m));
        end
        cyc(0, 4'b1011, 4'b0001, 1'b1, 1'b0, "nonowner_drop");
        cyc(0, 4'b1111, 4'b0001, 1'b1, 1'b0, "nonowner_rise");

        // Watchdog with TIMEOUT=8: eight grant cycles, then revoke to master 1.
        req_a = '0;
        do_reset(0, "reset_wd");
        for (int i = 0; i < 7; i++) begin
            cyc(0, 4'b0011, 4'b0001, 1'b1, 1'b0, "wd_hold0");
        end
        cyc(0, 4'b0011, 4'b0010, 1'b1, 1'b1, "wd_fire");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'b0011, 4'b0010, 1'b1, 1'b0, "wd_hold1");
        end
        cyc(0, 4'b0001, 4'b0010, 1'b0, 1'b0, "wd_masked_a");
        cyc(0, 4'b0001, 4'b0010, 1'b0, 1'b0, "wd_masked_b");
        cyc(0, 4'b0000, 4'b0010, 1'b0, 1'b0, "wd_unmask");
        cyc(0, 4'b0001, 4'b0001, 1'b1, 1'b0, "wd_regrant");

        // Reset between edges while master 3 owns the bus.
        cyc(0, 4'b1000, 4'b1000, 1'b1, 1'b0, "own3a");
        cyc(0, 4'b1000, 4'b1000, 1'b1, 1'b0, "own3b");
        #3;
        rst = 1'b1;
        #1;
        push(0, 4'b0001, 1'b0, 1'b0, "midrst");
        pop_chk();
        chk("midrst.mask", 32'(u_dut.r_mask), 32'd0);
        @(posedge clk);
        #1;
        push(0, 4'b0001, 1'b0, 1'b0, "midrst_held");
        pop_chk();
        rst = 1'b0;
        cyc(0, 4'b1000, 4'b1000, 1'b1, 1'b0, "resume");
        req_a = '0;

        // Sole requester with TIMEOUT=4.
        do_reset(1, "reset_wd4");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b0001, 4'b0001, 1'b1, 1'b0, "wd4_hold");
        end
        cyc(1, 4'b0001, 4'b0001, 1'b0, 1'b1, "wd4_fire");
        cyc(1, 4'b0001, 4'b0001, 1'b0, 1'b0, "wd4_masked_a");
        cyc(1, 4'b0001, 4'b0001, 1'b0, 1'b0, "wd4_masked_b");
        cyc(1, 4'b0000, 4'b0001, 1'b0, 1'b0, "wd4_drop");
        cyc(1, 4'b0001, 4'b0001, 1'b1, 1'b0, "wd4_rise");
        req_b = '0;

        // Watchdog disabled: long hold must neither revoke nor wrap the counter.
        do_reset(2, "reset_wd0");
        req_c = 4'b0011;
        bad   = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            if (gnt_c !== 4'b0001 || terr_c !== 1'b0) begin
                bad++;
            end
        end
        chk("wd0.glitches", 32'(bad), 32'd0);
        chk("wd0.cnt_sat", 32'(u_dut0.r_cnt), 32'h0000_FFFF);
        cyc(2, 4'b0011, 4'b0001, 1'b1, 1'b0, "wd0_still");
        chk("wd0.cnt_nowrap", 32'(u_dut0.r_cnt), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
